// File: rtl/id_ex_stage_pkg.sv
// Types shared by the ID/EX pipeline register and the ALU that consumes it.
package id_ex_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOR = 3'd5,
    ALU_LSL = 3'd6,
    ALU_LSR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    alu_op_e           op;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } id_ex_payload_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass select for one source register: x0, then EX/MEM, then MEM/WB, then register file.
module id_ex_stage_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   rf_val,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_val,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  output logic [XLEN-1:0]   operand
);

  always_comb begin
    operand = rf_val;
    if (src == '0) begin
      operand = '0;
    end else if (exm_we && (exm_rd == src)) begin
      operand = exm_val;
    end else if (wb_we && (wb_rd == src)) begin
      operand = wb_val;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: forwards operands at capture, valid/ready with flush,
// and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_val,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  stall_cnt
);
  import id_ex_stage_pkg::*;

  // Local payload layout follows the instance widths rather than the package defaults.
  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    alu_op_e           op;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } payload_t;

  logic [XLEN-1:0]  fwd_a;
  logic [XLEN-1:0]  fwd_b;
  payload_t         nxt;
  payload_t         pay_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src     (in_rs1),
    .rf_val  (in_rs1_val),
    .exm_we  (exm_we),
    .exm_rd  (exm_rd),
    .exm_val (exm_val),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_val  (wb_val),
    .operand (fwd_a)
  );

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src     (in_rs2),
    .rf_val  (in_rs2_val),
    .exm_we  (exm_we),
    .exm_rd  (exm_rd),
    .exm_val (exm_val),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_val  (wb_val),
    .operand (fwd_b)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    nxt       = '0;
    nxt.a     = fwd_a;
    nxt.b     = in_use_imm ? in_imm : fwd_b;
    nxt.op    = alu_op_e'(in_alu_op);
    nxt.rd    = in_rd;
    // Writes to x0 are dropped here so downstream never sees them.
    nxt.rd_we = in_rd_we && (in_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (flush) begin
        valid_q     <= 1'b0;
        pay_q.rd_we <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        pay_q   <= nxt;
      end else if (valid_q && out_ready) begin
        valid_q     <= 1'b0;
        pay_q.rd_we <= 1'b0;
      end

      // Counts every backpressured cycle, including one that is being flushed.
      if (valid_q && !out_ready && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = pay_q.a;
  assign alu_b     = pay_q.b;
  assign alu_op    = pay_q.op;
  assign out_rd    = pay_q.rd;
  assign out_rd_we = pay_q.rd_we;
  assign stall_cnt = cnt_q;

endmodule
